mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have EX/MEM-side inputs: MEM_re 1, MEM_we 1, MEM_mem_ALU_select 1, MEM_use_sprite_mem 1, MEM_use_dst_reg 1, MEM_hlt 1, MEM_dst_reg 5, MEM_addr 22, MEM_data 32 (store data), MEM_ALU_result 32, MEM_sprite_data 32, flush 1.
REQ-003 SHALL have data-memory port: dm_req out 1, dm_we out 1, dm_addr out 22, dm_wdata out 32, dm_ack in 1, dm_rdata in 32.
REQ-004 SHALL have outputs: mem_stall out 1 (holds EX/MEM and earlier stages), WB_valid out 1, WB_result out 32, WB_dst_reg out 5, WB_use_dst_reg out 1, WB_hlt out 1.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT; access = MEM_re | MEM_we, qualified by !WB_hlt.
REQ-006 IDLE with access: mem_stall=1 combinationally; next edge -> WAIT, dm_req=1, dm_addr/dm_wdata/dm_we registered from MEM_addr/MEM_data/MEM_we.
REQ-007 WAIT: dm_req, dm_addr, dm_wdata, dm_we SHALL stay stable until the cycle dm_ack=1.
REQ-008 WAIT, dm_ack=0: mem_stall=1; dm_ack=1: mem_stall=0 same cycle, next edge -> IDLE, dm_req=0.
REQ-009 Minimum access latency SHALL be 2 cycles (request cycle + ack cycle); no upper bound.
REQ-010 MEM_re & MEM_we both high SHALL be treated as a write (dm_we=1); no read data captured.
REQ-011 Result select: MEM_mem_ALU_select=1 -> dm_rdata captured on ack edge; else MEM_use_sprite_mem=1 -> MEM_sprite_data; else MEM_ALU_result.
REQ-012 WB_* SHALL register on each edge where mem_stall=0: WB_valid=1, WB_dst_reg, WB_use_dst_reg, WB_result per REQ-011.
REQ-013 Non-memory instruction SHALL pass to WB in 1 cycle, mem_stall=0.
REQ-014 flush in IDLE (mem_stall=0): next WB_valid=0, WB_use_dst_reg=0, no request issued.
REQ-015 flush during IDLE-with-access or WAIT: SHALL set a kill flag, complete the handshake unchanged (bus transactions are never aborted), then write WB_valid=0, WB_use_dst_reg=0; kill flag clears on return to IDLE.
REQ-016 MEM_hlt=1 with mem_stall=0 and no flush SHALL set WB_hlt sticky; afterwards no new requests, WB_valid=0.
REQ-017 dm_ack in IDLE SHALL be ignored.

Reset
REQ-018 rst_n low SHALL force IDLE, kill=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, WB_valid=0, WB_result=0, WB_dst_reg=0, WB_use_dst_reg=0, WB_hlt=0; mem_stall=0 while in reset.
REQ-019 Reset asserted mid-WAIT SHALL drop dm_req immediately; outstanding ack after reset ignored per REQ-017.

Configuration
REQ-020 Macro MEM_SPRITE_PATH_EN defined: REQ-011 sprite path present. Undefined: MEM_use_sprite_mem ignored, MEM_sprite_data unused, result = dm_rdata or MEM_ALU_result only.

Structure
REQ-021 Shared package mem_stage_pkg SHALL hold state enum (IDLE, WAIT), ADDR_W=22, DATA_W=32, REG_W=5.
REQ-022 Handshake FSM and request registers SHALL be sub-module mem_req_fsm; result mux and WB registers in the top.

Verification
REQ-023 Load, addr 0x00010, dm_ack 3 cycles after dm_req, rdata 0xDEADBEEF -> mem_stall high 4 cycles, WB_result=0xDEADBEEF, WB_valid 1 cycle.
REQ-024 Store addr 0x3FFFFF, data 0x12345678, ack next cycle -> dm_we=1, addr/data stable, 2-cycle stall, WB_use_dst_reg passes through.
REQ-025 ALU op result 0x0000_00FF, no access -> WB_result=0xFF one cycle later, mem_stall never high.
REQ-026 Flush asserted in WAIT, ack after 2 cycles -> handshake completes, WB_valid=0, next instruction proceeds normally.
REQ-027 MEM_hlt=1 then load presented -> WB_hlt=1 sticky, dm_req never asserts.
REQ-028 Reset pulsed mid-WAIT then late ack -> all outputs zero, state IDLE, ack ignored; sprite select with/without MEM_SPRITE_PATH_EN -> 0xA5A5A5A5 vs ALU result.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory pipeline stage.
package mem_stage_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Request payload presented on the data-memory port.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request handshake: issues one request per access, holds it
// stable until acknowledged, and remembers whether the access was flushed.
module mem_req_fsm
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    access_i,
    input  logic    flush_i,
    input  logic    dm_ack_i,
    input  dm_req_t req_i,
    output logic    dm_req_o,
    output dm_req_t bus_o,
    output logic    stall_c_o,
    output logic    done_c_o,
    output logic    kill_o
);

    mem_state_e state_q, state_d;
    logic       dm_req_q, dm_req_d;
    dm_req_t    bus_q, bus_d;
    logic       kill_q, kill_d;
    logic       stall_c;

    // State and request registers; reset drops the request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dm_req_q <= 1'b0;
            bus_q    <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dm_req_q <= dm_req_d;
            bus_q    <= bus_d;
            kill_q   <= kill_d;
        end
    end

    // Next-state, request capture and stall/done generation.
    always_comb begin
        state_d  = state_q;
        dm_req_d = dm_req_q;
        bus_d    = bus_q;
        kill_d   = kill_q;
        stall_c  = 1'b0;
        done_c_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_i) begin
                    stall_c  = 1'b1;
                    state_d  = WAIT;
                    dm_req_d = 1'b1;
                    bus_d    = req_i;
                    kill_d   = flush_i;
                end
            end
            WAIT: begin
                kill_d = kill_q | flush_i;
                if (dm_ack_i) begin
                    done_c_o = 1'b1;
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    kill_d   = 1'b0;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A stall requested while reset is asserted would freeze the pipeline, so mask it.
    assign stall_c_o = stall_c & rst_n;
    assign dm_req_o  = dm_req_q;
    assign bus_o     = bus_q;
    assign kill_o    = kill_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: drives the data-memory handshake, stalls the pipeline while
// an access is outstanding and registers the write-back result.
// Optional sprite result path enabled by defining MEM_SPRITE_PATH_EN.
module mem_access_unit
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_re,
    input  logic              MEM_we,
    input  logic              MEM_mem_ALU_select,
    input  logic              MEM_use_sprite_mem,
    input  logic              MEM_use_dst_reg,
    input  logic              MEM_hlt,
    input  logic [REG_W-1:0]  MEM_dst_reg,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_data,
    input  logic [DATA_W-1:0] MEM_ALU_result,
    input  logic [DATA_W-1:0] MEM_sprite_data,
    input  logic              flush,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              mem_stall,
    output logic              WB_valid,
    output logic [DATA_W-1:0] WB_result,
    output logic [REG_W-1:0]  WB_dst_reg,
    output logic              WB_use_dst_reg,
    output logic              WB_hlt
);

    logic              access_c;
    logic              stall_c;
    logic              done_c;
    logic              kill;
    dm_req_t           req_c;
    dm_req_t           bus;

    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_result_q, wb_result_d;
    logic [REG_W-1:0]  wb_dst_q, wb_dst_d;
    logic              wb_use_q, wb_use_d;
    logic              wb_hlt_q, wb_hlt_d;
    logic              kill_c;

    // Once halted, no further accesses are started.
    assign access_c = (MEM_re | MEM_we) & ~wb_hlt_q;
    assign req_c    = '{we: MEM_we, addr: MEM_addr, wdata: MEM_data};

    mem_req_fsm u_req_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .access_i (access_c),
        .flush_i  (flush),
        .dm_ack_i (dm_ack),
        .req_i    (req_c),
        .dm_req_o (dm_req),
        .bus_o    (bus),
        .stall_c_o(stall_c),
        .done_c_o (done_c),
        .kill_o   (kill)
    );

    assign dm_we     = bus.we;
    assign dm_addr   = bus.addr;
    assign dm_wdata  = bus.wdata;
    assign mem_stall = stall_c;

`ifndef MEM_SPRITE_PATH_EN
    logic unused_sprite;
    assign unused_sprite = ^{MEM_use_sprite_mem, MEM_sprite_data};
`endif

    // Result select and write-back qualification for the completing instruction.
    always_comb begin
        kill_c      = kill | flush;
        wb_valid_d  = ~kill_c & ~wb_hlt_q;
        wb_use_d    = MEM_use_dst_reg & wb_valid_d;
        wb_hlt_d    = wb_hlt_q | (MEM_hlt & ~kill_c);
        wb_dst_d    = MEM_dst_reg;
        wb_result_d = MEM_ALU_result;
        // A combined read/write is a store, so no read data is taken.
        if (done_c && MEM_mem_ALU_select && !MEM_we) begin
            wb_result_d = dm_rdata;
        end
`ifdef MEM_SPRITE_PATH_EN
        else if (MEM_use_sprite_mem) begin
            wb_result_d = MEM_sprite_data;
        end
`endif
    end

    // Write-back registers advance only when the stage is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_dst_q    <= '0;
            wb_use_q    <= 1'b0;
            wb_hlt_q    <= 1'b0;
        end else if (!stall_c) begin
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_dst_q    <= wb_dst_d;
            wb_use_q    <= wb_use_d;
            wb_hlt_q    <= wb_hlt_d;
        end
    end

    assign WB_valid       = wb_valid_q;
    assign WB_result      = wb_result_q;
    assign WB_dst_reg     = wb_dst_q;
    assign WB_use_dst_reg = wb_use_q;
    assign WB_hlt         = wb_hlt_q;

endmodule
